// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: instruction decode, register-file read, load-use stall
// detection and the ID/EX pipeline register.
// Optional feature macro: DECODE_WB_BYPASS_EN (write-through from write-back
// into the register-file read ports and a0_o in the same cycle).

// Main decoder: opcode class to control flags and ALU control.
module controlunit (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic       regwrite,
  output logic       resultsrc,
  output logic       memwrite,
  output logic       jbmux,
  output logic       pcwritemux,
  output logic       alusrc,
  output logic       addupper,
  output logic [3:0] aluctrl,
  output logic       uses_rs2
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Decode table; unknown opcodes produce an all-zero (harmless) control word.
  always_comb begin
    regwrite   = 1'b0;
    resultsrc  = 1'b0;
    memwrite   = 1'b0;
    jbmux      = 1'b0;
    pcwritemux = 1'b0;
    alusrc     = 1'b0;
    addupper   = 1'b0;
    aluctrl    = 4'd0;
    uses_rs2   = 1'b0;
    case (opcode)
      OP_R: begin
        regwrite = 1'b1;
        aluctrl  = {funct7b5, funct3};
        uses_rs2 = 1'b1;
      end
      OP_I: begin
        regwrite = 1'b1;
        alusrc   = 1'b1;
        // Only shift-right immediates use bit 30 (SRAI vs SRLI).
        aluctrl  = (funct3 == 3'b101) ? {funct7b5, funct3} : {1'b0, funct3};
      end
      OP_LOAD: begin
        regwrite  = 1'b1;
        resultsrc = 1'b1;
        alusrc    = 1'b1;
      end
      OP_STORE: begin
        memwrite = 1'b1;
        alusrc   = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        aluctrl  = 4'b1000;
        uses_rs2 = 1'b1;
      end
      OP_JAL: begin
        regwrite   = 1'b1;
        pcwritemux = 1'b1;
      end
      OP_JALR: begin
        regwrite   = 1'b1;
        jbmux      = 1'b1;
        pcwritemux = 1'b1;
        alusrc     = 1'b1;
      end
      OP_LUI: begin
        regwrite = 1'b1;
        alusrc   = 1'b1;
        aluctrl  = 4'b1111;
      end
      OP_AUIPC: begin
        regwrite = 1'b1;
        alusrc   = 1'b1;
        addupper = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// Immediate generator for I/S/B/J/U formats, sign-extended to XLEN.
module signextender #(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);
  logic [31:0] imm32;

  // Reassemble the scattered immediate fields per instruction format.
  always_comb begin
    imm32 = 32'd0;
    case (instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111:
        imm32 = {{20{instr[31]}}, instr[31:20]};
      7'b0100011:
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      7'b1100011:
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      7'b1101111:
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      7'b0110111, 7'b0010111:
        imm32 = {instr[31:12], 12'd0};
      default: imm32 = 32'd0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));
endmodule

module decode_stage_pipe #(
  parameter  int unsigned XLEN   = 32,
  parameter  int unsigned NREGS  = 32,
  parameter  int unsigned A0_IDX = 10,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pcplusfour_i,
  input  logic            flush_i,
  input  logic            wb_we_i,
  input  logic [AW-1:0]   wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            trigger_i,
  output logic            stall_o,
  output logic [XLEN-1:0] a0_o,
  output logic            ex_valid_o,
  output logic            ex_regwrite_o,
  output logic            ex_resultsrc_o,
  output logic            ex_memwrite_o,
  output logic            ex_jbmux_o,
  output logic            ex_pcwritemux_o,
  output logic            ex_alusrc_o,
  output logic            ex_addupper_o,
  output logic [3:0]      ex_aluctrl_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_pcplusfour_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [XLEN-1:0] ex_rd1_o,
  output logic [XLEN-1:0] ex_rd2_o,
  output logic [AW-1:0]   ex_rs1_o,
  output logic [AW-1:0]   ex_rs2_o,
  output logic [AW-1:0]   ex_rd_o
);
  logic [XLEN-1:0] regs [NREGS];
  logic [AW-1:0]   rs1, rs2, rd;
  logic [XLEN-1:0] rd1, rd2, imm;
  logic            regwrite, resultsrc, memwrite, jbmux, pcwritemux, alusrc, addupper;
  logic [3:0]      aluctrl;
  logic            uses_rs2, hz, clear;
  logic            unused_trigger;

  // trigger_i has no function in this register-file variant; kept for port compatibility.
  assign unused_trigger = trigger_i;

  assign rs1 = AW'(instr_i[19:15]);
  assign rs2 = AW'(instr_i[24:20]);
  assign rd  = AW'(instr_i[11:7]);

  controlunit u_cu (
    .opcode     (instr_i[6:0]),
    .funct3     (instr_i[14:12]),
    .funct7b5   (instr_i[30]),
    .regwrite   (regwrite),
    .resultsrc  (resultsrc),
    .memwrite   (memwrite),
    .jbmux      (jbmux),
    .pcwritemux (pcwritemux),
    .alusrc     (alusrc),
    .addupper   (addupper),
    .aluctrl    (aluctrl),
    .uses_rs2   (uses_rs2)
  );

  signextender #(.XLEN(XLEN)) u_se (
    .instr (instr_i),
    .imm   (imm)
  );

  // Register-file write port; x0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_we_i && (wb_addr_i != '0)) begin
      regs[wb_addr_i] <= wb_data_i;
    end
  end

  // Combinational read ports with x0 forced to zero and optional write-through.
  always_comb begin
    rd1  = regs[rs1];
    rd2  = regs[rs2];
    a0_o = regs[AW'(A0_IDX)];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_we_i && (wb_addr_i != '0)) begin
      if (wb_addr_i == rs1)           rd1  = wb_data_i;
      if (wb_addr_i == rs2)           rd2  = wb_data_i;
      if (wb_addr_i == AW'(A0_IDX))   a0_o = wb_data_i;
    end
`endif
    if (rs1 == '0) rd1 = '0;
    if (rs2 == '0) rd2 = '0;
  end

  // Load-use hazard against the load currently sitting in ID/EX.
  assign hz = ex_valid_o & ex_resultsrc_o & (ex_rd_o != '0) & valid_i &
              ((ex_rd_o == rs1) | (uses_rs2 & (ex_rd_o == rs2)));
  assign stall_o = hz & ~flush_i & ~rst;

  // Reset, flush, stall bubble and empty decode slot all load an all-zero ID/EX word.
  assign clear = rst | flush_i | stall_o | ~valid_i;

  // ID/EX pipeline register.
  always_ff @(posedge clk) begin
    if (clear) begin
      ex_valid_o      <= 1'b0;
      ex_regwrite_o   <= 1'b0;
      ex_resultsrc_o  <= 1'b0;
      ex_memwrite_o   <= 1'b0;
      ex_jbmux_o      <= 1'b0;
      ex_pcwritemux_o <= 1'b0;
      ex_alusrc_o     <= 1'b0;
      ex_addupper_o   <= 1'b0;
      ex_aluctrl_o    <= 4'd0;
      ex_pc_o         <= '0;
      ex_pcplusfour_o <= '0;
      ex_imm_o        <= '0;
      ex_rd1_o        <= '0;
      ex_rd2_o        <= '0;
      ex_rs1_o        <= '0;
      ex_rs2_o        <= '0;
      ex_rd_o         <= '0;
    end else begin
      ex_valid_o      <= 1'b1;
      ex_regwrite_o   <= regwrite;
      ex_resultsrc_o  <= resultsrc;
      ex_memwrite_o   <= memwrite;
      ex_jbmux_o      <= jbmux;
      ex_pcwritemux_o <= pcwritemux;
      ex_alusrc_o     <= alusrc;
      ex_addupper_o   <= addupper;
      ex_aluctrl_o    <= aluctrl;
      ex_pc_o         <= pc_i;
      ex_pcplusfour_o <= pcplusfour_i;
      ex_imm_o        <= imm;
      ex_rd1_o        <= rd1;
      ex_rd2_o        <= rd2;
      ex_rs1_o        <= rs1;
      ex_rs2_o        <= rs2;
      ex_rd_o         <= rd;
    end
  end
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Self-checking bench for decode_stage_pipe: directed test-plan steps followed
// by random instruction streams, checked against a behavioural model.
// Honors DECODE_WB_BYPASS_EN when the macro is defined for the build.
module tb_decode_stage_pipe;
  logic        clk = 1'b0;
  logic        rst, valid_i, flush_i, wb_we_i, trigger_i;
  logic [31:0] instr_i, pc_i, pcplusfour_i, wb_data_i;
  logic [4:0]  wb_addr_i;
  logic        stall_o, ex_valid_o;
  logic        ex_regwrite_o, ex_resultsrc_o, ex_memwrite_o, ex_jbmux_o;
  logic        ex_pcwritemux_o, ex_alusrc_o, ex_addupper_o;
  logic [3:0]  ex_aluctrl_o;
  logic [31:0] a0_o, ex_pc_o, ex_pcplusfour_o, ex_imm_o, ex_rd1_o, ex_rd2_o;
  logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;

  always #5 clk = ~clk;

  decode_stage_pipe dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .instr_i(instr_i), .pc_i(pc_i),
    .pcplusfour_i(pcplusfour_i), .flush_i(flush_i), .wb_we_i(wb_we_i),
    .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .trigger_i(trigger_i),
    .stall_o(stall_o), .a0_o(a0_o), .ex_valid_o(ex_valid_o),
    .ex_regwrite_o(ex_regwrite_o), .ex_resultsrc_o(ex_resultsrc_o),
    .ex_memwrite_o(ex_memwrite_o), .ex_jbmux_o(ex_jbmux_o),
    .ex_pcwritemux_o(ex_pcwritemux_o), .ex_alusrc_o(ex_alusrc_o),
    .ex_addupper_o(ex_addupper_o), .ex_aluctrl_o(ex_aluctrl_o),
    .ex_pc_o(ex_pc_o), .ex_pcplusfour_o(ex_pcplusfour_o), .ex_imm_o(ex_imm_o),
    .ex_rd1_o(ex_rd1_o), .ex_rd2_o(ex_rd2_o), .ex_rs1_o(ex_rs1_o),
    .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Model state: architectural registers and what the model believes is in ID/EX.
  logic [31:0] m_rf [32];
  logic        m_ex_valid = 1'b0;
  logic        m_ex_load  = 1'b0;
  logic [4:0]  m_ex_rd    = 5'd0;
  logic        last_stall = 1'b0;
  logic        obs_stall  = 1'b0;

  // Opcode per instruction class; the last entry is an undefined opcode.
  logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};

  // ctl = {regwrite, resultsrc, memwrite, jbmux, pcwritemux, alusrc, addupper, aluctrl[3:0]}
  typedef struct packed {
    logic [10:0] ctl;
    logic [31:0] imm;
    logic        use2;
    logic        is_load;
  } dec_t;

  function automatic dec_t decode_ref(input logic [31:0] ins);
    dec_t d;
    int   hi;
    logic [2:0] f3;
    d  = '0;
    f3 = ins[14:12];
    hi = $signed(ins) >>> 31;
    case (ins[6:0])
      7'b0110011: begin d.ctl = {7'b1000000, ins[30], f3}; d.use2 = 1'b1; end
      7'b0010011: begin
        d.ctl = {7'b1000010, (f3 == 3'd5) ? ins[30] : 1'b0, f3};
        d.imm = 32'($signed(ins) >>> 20);
      end
      7'b0000011: begin
        d.ctl = {7'b1100010, 4'd0}; d.imm = 32'($signed(ins) >>> 20); d.is_load = 1'b1;
      end
      7'b0100011: begin
        d.ctl  = {7'b0010010, 4'd0};
        d.imm  = 32'(($signed(ins) >>> 25) * 32 + int'(ins[11:7]));
        d.use2 = 1'b1;
      end
      7'b1100011: begin
        d.ctl  = {7'b0000000, 4'd8};
        d.imm  = 32'(hi * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2);
        d.use2 = 1'b1;
      end
      7'b1101111: begin
        d.ctl = {7'b1000100, 4'd0};
        d.imm = 32'(hi * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2);
      end
      7'b1100111: begin d.ctl = {7'b1001110, 4'd0}; d.imm = 32'($signed(ins) >>> 20); end
      7'b0110111: begin d.ctl = {7'b1000010, 4'd15}; d.imm = ins & 32'hFFFFF000; end
      7'b0010111: begin d.ctl = {7'b1000011, 4'd0};  d.imm = ins & 32'hFFFFF000; end
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] read_ref(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return m_rf[a];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  // One clock: drive, check combinational stall, clock, check ID/EX and a0, advance model.
  task automatic cycle(input logic r, input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    dec_t d;
    logic [4:0]  rs1, rs2, rd;
    logic        e_stall, clr, bubble;
    logic [31:0] e_rd1, e_rd2;
    rst = r; valid_i = v; instr_i = ins; pc_i = pc; pcplusfour_i = pc + 32'd4;
    flush_i = fl; wb_we_i = we; wb_addr_i = wa; wb_data_i = wd; trigger_i = 1'($urandom);
    #1;
    d   = decode_ref(ins);
    rs1 = ins[19:15]; rs2 = ins[24:20]; rd = ins[11:7];
    e_stall = !r && !fl && v && m_ex_valid && m_ex_load && (m_ex_rd != 5'd0) &&
              ((m_ex_rd == rs1) || (d.use2 && (m_ex_rd == rs2)));
    obs_stall = stall_o;
    check("stall", 64'(stall_o), 64'(e_stall));
    e_rd1  = read_ref(rs1, we, wa, wd);
    e_rd2  = read_ref(rs2, we, wa, wd);
    clr    = r || fl;
    bubble = clr || e_stall || !v;
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    end else if (we && wa != 5'd0) begin
      m_rf[wa] = wd;
    end
    check("ex_valid", 64'(ex_valid_o), 64'(!bubble));
    check("ex_ctl", 64'({ex_regwrite_o, ex_resultsrc_o, ex_memwrite_o, ex_jbmux_o,
                         ex_pcwritemux_o, ex_alusrc_o, ex_addupper_o, ex_aluctrl_o}),
          64'(bubble ? 11'd0 : d.ctl));
    if (clr || !bubble) begin
      check("ex_pc",   64'(ex_pc_o),         64'(clr ? 32'd0 : pc));
      check("ex_pc4",  64'(ex_pcplusfour_o), 64'(clr ? 32'd0 : pc + 32'd4));
      check("ex_imm",  64'(ex_imm_o),        64'(clr ? 32'd0 : d.imm));
      check("ex_rd1",  64'(ex_rd1_o),        64'(clr ? 32'd0 : e_rd1));
      check("ex_rd2",  64'(ex_rd2_o),        64'(clr ? 32'd0 : e_rd2));
      check("ex_regs", 64'({ex_rs1_o, ex_rs2_o, ex_rd_o}), 64'(clr ? 15'd0 : {rs1, rs2, rd}));
    end
    check("a0", 64'(a0_o), 64'(read_ref(5'd10, we, wa, wd)));
    m_ex_valid = !bubble;
    m_ex_load  = !bubble && d.is_load;
    m_ex_rd    = bubble ? 5'd0 : rd;
    last_stall = e_stall;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins        = $urandom;
    ins[6:0]   = ops[$urandom_range(0, 9)];
    ins[11:7]  = 5'($urandom_range(0, 7));
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  initial begin
    logic [31:0] ins, pc;
    logic        hold, v, fl, we, r;
    logic [4:0]  wa;
    // Reset: everything cleared, no stall.
    cycle(1, 0, 32'd0, 32'd0, 0, 0, 5'd0, 32'd0);
    cycle(1, 1, r_add(6, 5, 5), 32'h40, 0, 0, 5'd0, 32'd0);
    check("tp_reset_valid", 64'(ex_valid_o), 64'd0);

    // Write x5 then add x6,x5,x5.
    cycle(0, 0, 32'd0, 32'd0, 0, 1, 5'd5, 32'h1234);
    cycle(0, 1, r_add(6, 5, 5), 32'h100, 0, 1, 5'd1, 32'h80);
    check("tp_add_rd1", 64'(ex_rd1_o), 64'h1234);
    check("tp_add_rd2", 64'(ex_rd2_o), 64'h1234);
    check("tp_add_rd",  64'(ex_rd_o), 64'd6);
    check("tp_add_rw",  64'(ex_regwrite_o), 64'd1);

    // lw x7 then dependent add: one stall cycle, bubble, then issue.
    cycle(0, 1, lw(7, 1), 32'h104, 0, 1, 5'd2, 32'h22);
    cycle(0, 1, r_add(8, 7, 2), 32'h108, 0, 0, 5'd0, 32'd0);
    check("tp_stall_hi", 64'(obs_stall), 64'd1);
    check("tp_bubble_rw", 64'(ex_regwrite_o), 64'd0);
    cycle(0, 1, r_add(8, 7, 2), 32'h108, 0, 0, 5'd0, 32'd0);
    check("tp_stall_lo", 64'(obs_stall), 64'd0);
    check("tp_issue_rs1", 64'(ex_rs1_o), 64'd7);

    // Independent add after load; load to x0 followed by add x8,x0,x0.
    cycle(0, 1, lw(7, 1), 32'h10C, 0, 0, 5'd0, 32'd0);
    cycle(0, 1, r_add(8, 2, 3), 32'h110, 0, 0, 5'd0, 32'd0);
    check("tp_nodep", 64'(obs_stall), 64'd0);
    cycle(0, 1, lw(0, 1), 32'h114, 0, 0, 5'd0, 32'd0);
    cycle(0, 1, r_add(8, 0, 0), 32'h118, 0, 0, 5'd0, 32'd0);
    check("tp_x0load", 64'(obs_stall), 64'd0);

    // Flush coinciding with a load-use hazard.
    cycle(0, 1, lw(7, 1), 32'h11C, 0, 0, 5'd0, 32'd0);
    cycle(0, 1, r_add(8, 7, 2), 32'h120, 1, 0, 5'd0, 32'd0);
    check("tp_flush_stall", 64'(obs_stall), 64'd0);
    check("tp_flush_valid", 64'(ex_valid_o), 64'd0);

    // x0 write ignored; x10 mirrored on a0_o.
    cycle(0, 0, 32'd0, 32'd0, 0, 1, 5'd0, 32'hFFFFFFFF);
    cycle(0, 1, r_add(9, 0, 0), 32'h124, 0, 1, 5'd10, 32'hAB);
    check("tp_x0_read", 64'(ex_rd1_o), 64'd0);
    check("tp_a0", 64'(a0_o), 64'hAB);

    // Same-cycle write-back and read of x3.
    cycle(0, 0, 32'd0, 32'd0, 0, 1, 5'd3, 32'h11);
    cycle(0, 1, r_add(4, 3, 0), 32'h128, 0, 1, 5'd3, 32'h55);
`ifdef DECODE_WB_BYPASS_EN
    check("tp_bypass", 64'(ex_rd1_o), 64'h55);
`else
    check("tp_bypass", 64'(ex_rd1_o), 64'h11);
`endif

    // Reset asserted while a stall would occur.
    cycle(0, 1, lw(7, 1), 32'h12C, 0, 0, 5'd0, 32'd0);
    cycle(1, 1, r_add(8, 7, 2), 32'h130, 0, 0, 5'd0, 32'd0);
    check("tp_rst_stall", 64'(obs_stall), 64'd0);

    // Random streams; fetch re-presents the same instruction after a stall.
    hold = 1'b0; ins = 32'd0; pc = 32'd0;
    for (int n = 0; n < 600; n++) begin
      if (!hold) begin
        ins = rand_instr();
        pc  = $urandom & 32'hFFFFFFFC;
        v   = ($urandom_range(0, 7) != 0);
      end else begin
        v = 1'b1;
      end
      fl = ($urandom_range(0, 15) == 0);
      r  = ($urandom_range(0, 99) == 0);
      we = r ? 1'b0 : 1'($urandom);
      wa = ($urandom_range(0, 5) == 0) ? 5'd10 : 5'($urandom_range(0, 7));
      cycle(r, v, ins, pc, fl, we, wa, $urandom);
      hold = last_stall;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
